sysx_slave_endpoint: RTL and testbench
======================================

# sysx_slave_endpoint

Downstream peer of the sysX master controller: a peripheral-side endpoint that decodes the master's 8-bit parallel bus frames, delivering each received 32-bit word into an RX FIFO and returning a 32-bit word from a TX FIFO in the same frame. Sits inside every sysX peripheral between the backplane pins and the peripheral's local logic. It oversamples the bus clock with the local system clock, so the whole block runs on one clock domain.

## Interface

- pDeviceSelect, 2'h1: bus select code this endpoint answers to; 2'h0 is reserved for idle.
- pFifoDepth, 8: entries per FIFO; must be a power of two, at least 2.
- pIdleWord, 32'h0BADC0DE: word returned when the TX FIFO is empty.
- iClock  in  1  local system clock; all logic on its rising edge.
- iReset  in  1  synchronous, active-low reset.
- iBusClock  in  1  sysX bus clock from the master; idles high.
- iBusSelect  in  2  sysX chip select; 0 means idle.
- iBusMOSI  in  8  master-to-slave byte lane.
- oBusMISO  out  8  slave-to-master byte lane.
- oBusInterrupt  out  1  interrupt request to the master.
- oRxData  out  32  head of the RX FIFO.
- oRxValid  out  1  RX FIFO not empty.
- iRxReady  in  1  local side pops RX when this and oRxValid are both high.
- iTxData  in  32  word to queue for the master.
- iTxValid  in  1  local side pushes TX when this and oTxReady are both high.
- oTxReady  out  1  TX FIFO not full.
- iIntRequest  in  1  local interrupt source.
- iClearErrors  in  1  clears the sticky error flags.
- oErrors  out  3  sticky flags: {frame, underflow, overflow}.

## Operation

- **Synchronizer:** iBusClock, iBusSelect and iBusMOSI each pass through two flops. A third flop on the clock gives edge detection. A fall is detected when stage 2 is 0 and stage 3 is 1. Selected means synced select equals pDeviceSelect.
- **Frame:** a frame is six bus periods, Load, B0, B1, B2, B3, Store, in that order. Bytes are sent least-significant first. In block mode, frames run back to back.
- **State machine** (package enum): sIdle, sByte0, sByte1, sByte2, sByte3, sStore. It advances only on a detected fall while selected.
  - sIdle: latch the TX shift word, either the TX head or pIdleWord if TX is empty. Drive byte 0 and go to sByte0.
  - sByteN: capture synced MOSI into rx[8N+7:8N]. For N<3, drive TX byte N+1 and go to sByte(N+1). For N=3, go to sStore.
  - sStore: push the rx word to the RX FIFO and pop TX if a real word was latched. Go to sIdle.
- **Bus outputs:**
  - oBusMISO is 8'h00 whenever not selected or in sIdle before the first fall.
  - oBusInterrupt = iIntRequest OR oRxValid.
- **Errors:**
  - Overflow: a Store occurs while RX is full. The word is dropped.
  - Underflow: the TX word is latched from an empty TX FIFO.
  - Frame: select leaves pDeviceSelect while the state is not sIdle. The machine returns to sIdle with no push and no pop.
  - iClearErrors clears all three flags. A set event in the same cycle wins.
- **Simultaneous events:**
  - Bus push and local pop on the RX FIFO in the same cycle are legal, even when full. The pop frees the slot first, so no overflow is raised.
  - The same applies to a TX pop and local push.

## Timing

- **Reset (iReset low at a clock edge):** state sIdle, both FIFOs empty, oErrors 0, oBusMISO 8'h00, oRxValid 0, oTxReady 1. oBusInterrupt follows iIntRequest.
- **Reset mid-frame:** the partial frame is discarded silently, with no error flag set.
- **Fall detection:** a bus fall is acted on 3 iClock cycles after the pin transition.
- **MISO update:** oBusMISO updates the cycle after detection. Each bus half-period must therefore be at least 5 iClock cycles.
- **RX latency:** oRxValid rises 1 cycle after the Store fall is detected.
- **TX and interrupt:** oTxReady and oBusInterrupt are registered-FIFO flags with 1 cycle latency.
- **FIFO counters:** read and write pointers are log2(pFifoDepth) bits and wrap around. Occupancy is log2(pFifoDepth)+1 bits.

## Structure

- **Package sysx_pkg:** holds the state enum, reserved select code 2'h0, default idle word, and error bit indices. It is shared with the master controller.
- **Sub-module sysx_sync_fifo:** a single-clock FIFO with parameterized width and depth, full/empty flags and a pop-before-push rule. It is instantiated twice, once for RX and once for TX.

## Test plan

1. Reset, queue TX 32'h11223344, run one frame sending MOSI bytes 0xAA 0xBB 0xCC 0xDD. Required: MISO bytes 0x44 0x33 0x22 0x11; oRxData = 32'hDDCCBBAA; oErrors = 0.
2. Run a frame with TX empty. Required: MISO shows 0xDE 0xC0 0xAD 0x0B; underflow flag set; RX receives the word.
3. Run pFifoDepth+1 back-to-back frames with iRxReady low. Required: RX full after pFifoDepth frames; last word dropped; overflow flag set; then iClearErrors clears the flags.
4. Drop select after sByte1. Required: frame flag set; RX count unchanged; TX head unchanged and returned by the next frame.
5. Run a frame with iBusSelect = 2'h2 against pDeviceSelect = 2'h1. Required: oBusMISO stays 8'h00; no state change.
6. Drive iReset low during sByte2, then run a complete frame. Required: all outputs at reset values; the following frame decodes correctly.

Source files
------------

// File: rtl/sysx_pkg.sv
// -----------------------------------------------------------------------------
// sysx_pkg
// Definitions shared between the sysX master controller and the slave
// endpoint: frame state encoding, the reserved idle select code, the default
// idle word returned on TX underflow, the sticky error bit positions and a
// byte-lane extraction helper.
// -----------------------------------------------------------------------------
package sysx_pkg;

  // One state per bus period of a frame: Load, B0, B1, B2, B3, Store.
  typedef enum logic [2:0] {
    sIdle  = 3'd0,
    sByte0 = 3'd1,
    sByte1 = 3'd2,
    sByte2 = 3'd3,
    sByte3 = 3'd4,
    sStore = 3'd5
  } sysxState;

  localparam logic [1:0]  cSelectIdle      = 2'h0;
  localparam logic [31:0] cDefaultIdleWord = 32'h0BADC0DE;

  // Bit positions inside oErrors = {frame, underflow, overflow}.
  localparam int cErrOverflow  = 0;
  localparam int cErrUnderflow = 1;
  localparam int cErrFrame     = 2;

  // Byte lane idx of a 32-bit word, lane 0 being the least significant.
  function automatic logic [7:0] sysxByte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] lane;
    case (idx)
      2'd0:    lane = word[7:0];
      2'd1:    lane = word[15:8];
      2'd2:    lane = word[23:16];
      2'd3:    lane = word[31:24];
      default: lane = 8'h00;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/sysx_slave_endpoint_if.sv
// -----------------------------------------------------------------------------
// sysx_slave_endpoint_if
// sysX backplane pins between the master controller and one endpoint.
//   iBusClock     master -> slave  bus clock, idles high
//   iBusSelect    master -> slave  chip select code, 2'h0 = idle
//   iBusMOSI      master -> slave  byte lane
//   oBusMISO      slave -> master  byte lane
//   oBusInterrupt slave -> master  interrupt request
// Signal names are seen from the endpoint's side of the bus.
// -----------------------------------------------------------------------------
interface sysx_slave_endpoint_if;
  logic       iBusClock;
  logic [1:0] iBusSelect;
  logic [7:0] iBusMOSI;
  logic [7:0] oBusMISO;
  logic       oBusInterrupt;

  modport master (
    output iBusClock,
    output iBusSelect,
    output iBusMOSI,
    input  oBusMISO,
    input  oBusInterrupt
  );

  modport slave (
    input  iBusClock,
    input  iBusSelect,
    input  iBusMOSI,
    output oBusMISO,
    output oBusInterrupt
  );
endinterface

// File: rtl/sysx_sync_fifo.sv
// -----------------------------------------------------------------------------
// sysx_sync_fifo
// Single-clock FIFO with registered empty/full flags. A pop and a push in
// the same cycle are both accepted even when full: the pop frees the slot
// first. Pushes to a full FIFO without a pop are ignored; the caller decides
// whether that is an error.
//   iClock    system clock
//   iReset    synchronous active-low reset
//   iPush     write request, iPushData written when accepted
//   iPop      read request, ignored while empty
//   oHead     oldest entry (undefined while empty)
//   oEmpty    no entries
//   oFull     pDepth entries
// pDepth must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sysx_sync_fifo #(
  parameter int pWidth = 32,
  parameter int pDepth = 8
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iPush,
  input  logic [pWidth-1:0] iPushData,
  input  logic              iPop,
  output logic [pWidth-1:0] oHead,
  output logic              oEmpty,
  output logic              oFull
);

  localparam int cPtrW = $clog2(pDepth);
  localparam int cCntW = cPtrW + 1;

  logic [pWidth-1:0] memR [pDepth];
  logic [cPtrW-1:0]  wrPtrR;
  logic [cPtrW-1:0]  rdPtrR;
  logic [cCntW-1:0]  countR;
  logic [cCntW-1:0]  countNext;
  logic              emptyR;
  logic              fullR;
  logic              doPop;
  logic              doPush;

  // Accept rules and next occupancy; a pop frees space for a same-cycle push.
  always_comb begin
    doPop  = iPop && !emptyR;
    doPush = iPush && (!fullR || doPop);
    if (doPush && !doPop) begin
      countNext = countR + cCntW'(1);
    end else if (doPop && !doPush) begin
      countNext = countR - cCntW'(1);
    end else begin
      countNext = countR;
    end
  end

  // Storage array; data contents need no reset.
  always_ff @(posedge iClock) begin
    if (doPush) begin
      memR[wrPtrR] <= iPushData;
    end
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      wrPtrR <= '0;
      rdPtrR <= '0;
      countR <= '0;
      emptyR <= 1'b1;
      fullR  <= 1'b0;
    end else begin
      if (doPush) begin
        wrPtrR <= wrPtrR + cPtrW'(1);
      end
      if (doPop) begin
        rdPtrR <= rdPtrR + cPtrW'(1);
      end
      countR <= countNext;
      emptyR <= (countNext == cCntW'(0));
      fullR  <= (countNext == cCntW'(pDepth));
    end
  end

  assign oHead  = memR[rdPtrR];
  assign oEmpty = emptyR;
  assign oFull  = fullR;

endmodule

// File: rtl/sysx_slave_endpoint.sv
// -----------------------------------------------------------------------------
// sysx_slave_endpoint
// Peripheral-side endpoint of the sysX parallel bus. The bus pins are
// oversampled by iClock; each frame (Load, B0..B3, Store) returns one 32-bit
// TX word byte-serially on MISO and collects one 32-bit MOSI word into RX.
//   iClock, iReset   system clock, synchronous active-low reset
//   bus (slave)      sysX backplane pins
//   oRxData/oRxValid/iRxReady  RX FIFO head and pop handshake
//   iTxData/iTxValid/oTxReady  TX FIFO push handshake
//   iIntRequest      local interrupt source, ORed with RX-not-empty
//   iClearErrors     clears oErrors = {frame, underflow, overflow}
// -----------------------------------------------------------------------------
module sysx_slave_endpoint
  import sysx_pkg::*;
#(
  parameter logic [1:0]  pDeviceSelect = 2'h1,
  parameter int          pFifoDepth    = 8,
  parameter logic [31:0] pIdleWord     = cDefaultIdleWord
) (
  input  logic                        iClock,
  input  logic                        iReset,
  sysx_slave_endpoint_if.slave        bus,
  output logic [31:0]                 oRxData,
  output logic                        oRxValid,
  input  logic                        iRxReady,
  input  logic [31:0]                 iTxData,
  input  logic                        iTxValid,
  output logic                        oTxReady,
  input  logic                        iIntRequest,
  input  logic                        iClearErrors,
  output logic [2:0]                  oErrors
);

  // Synchronizer stages.
  logic       busClkS1R;
  logic       busClkS2R;
  logic       busClkS3R;
  logic [1:0] selS1R;
  logic [1:0] selS2R;
  logic [7:0] mosiS1R;
  logic [7:0] mosiS2R;

  logic       busFall;
  logic       selected;

  // Frame machine registers.
  sysxState   stateR;
  logic [31:0] txShiftR;
  logic        txRealR;
  logic [31:0] rxShiftR;
  logic [7:0]  misoR;
  logic [2:0]  errR;

  // FIFO side.
  logic [31:0] rxHead;
  logic        rxEmpty;
  logic        rxFull;
  logic        rxPush;
  logic        rxPop;
  logic [31:0] txHead;
  logic        txEmpty;
  logic        txFull;
  logic        txPush;
  logic        txPop;
  logic [31:0] txWord;

  // Per-cycle events.
  logic        frameEvt;
  logic        underflowEvt;
  logic        overflowEvt;
  logic [2:0]  errSet;

  // Two-flop synchronizers; the third clock stage feeds fall detection.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      busClkS1R <= 1'b1;
      busClkS2R <= 1'b1;
      busClkS3R <= 1'b1;
      selS1R    <= cSelectIdle;
      selS2R    <= cSelectIdle;
      mosiS1R   <= 8'h00;
      mosiS2R   <= 8'h00;
    end else begin
      busClkS1R <= bus.iBusClock;
      busClkS2R <= busClkS1R;
      busClkS3R <= busClkS2R;
      selS1R    <= bus.iBusSelect;
      selS2R    <= selS1R;
      mosiS1R   <= bus.iBusMOSI;
      mosiS2R   <= mosiS1R;
    end
  end

  assign busFall  = !busClkS2R && busClkS3R;
  assign selected = (selS2R == pDeviceSelect);

  // An empty TX FIFO is answered with the idle word.
  assign txWord = txEmpty ? pIdleWord : txHead;

  // Frame machine: advances one state per detected bus fall while selected.
  // Losing select aborts the frame and silences MISO.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      stateR   <= sIdle;
      txShiftR <= 32'h0000_0000;
      txRealR  <= 1'b0;
      rxShiftR <= 32'h0000_0000;
      misoR    <= 8'h00;
    end else if (!selected) begin
      stateR <= sIdle;
      misoR  <= 8'h00;
    end else if (busFall) begin
      case (stateR)
        sIdle: begin
          txShiftR <= txWord;
          txRealR  <= !txEmpty;
          misoR    <= sysxByte(txWord, 2'd0);
          stateR   <= sByte0;
        end
        sByte0: begin
          rxShiftR[7:0] <= mosiS2R;
          misoR         <= sysxByte(txShiftR, 2'd1);
          stateR        <= sByte1;
        end
        sByte1: begin
          rxShiftR[15:8] <= mosiS2R;
          misoR          <= sysxByte(txShiftR, 2'd2);
          stateR         <= sByte2;
        end
        sByte2: begin
          rxShiftR[23:16] <= mosiS2R;
          misoR           <= sysxByte(txShiftR, 2'd3);
          stateR          <= sByte3;
        end
        sByte3: begin
          rxShiftR[31:24] <= mosiS2R;
          stateR          <= sStore;
        end
        sStore: begin
          misoR  <= 8'h00;
          stateR <= sIdle;
        end
        default: begin
          misoR  <= 8'h00;
          stateR <= sIdle;
        end
      endcase
    end else begin
      stateR <= stateR;
    end
  end

  // FIFO strobes and error events decoded from the current state and bus fall.
  always_comb begin
    rxPush       = 1'b0;
    txPop        = 1'b0;
    underflowEvt = 1'b0;
    frameEvt     = 1'b0;
    if (selected && busFall) begin
      case (stateR)
        sIdle: begin
          underflowEvt = txEmpty;
        end
        sStore: begin
          rxPush = 1'b1;
          txPop  = txRealR;
        end
        default: begin
          rxPush = 1'b0;
        end
      endcase
    end else if (!selected && (stateR != sIdle)) begin
      frameEvt = 1'b1;
    end else begin
      frameEvt = 1'b0;
    end
  end

  assign rxPop  = iRxReady && !rxEmpty;
  assign txPush = iTxValid && !txFull;

  // A same-cycle local pop makes room, so only a push with no pop overflows.
  assign overflowEvt = rxPush && rxFull && !rxPop;

  // Collect this cycle's error events into flag positions.
  always_comb begin
    errSet                = 3'b000;
    errSet[cErrOverflow]  = overflowEvt;
    errSet[cErrUnderflow] = underflowEvt;
    errSet[cErrFrame]     = frameEvt;
  end

  // Sticky error flags; a new event wins over a simultaneous clear.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      errR <= 3'b000;
    end else begin
      errR <= (iClearErrors ? 3'b000 : errR) | errSet;
    end
  end

  sysx_sync_fifo #(
    .pWidth (32),
    .pDepth (pFifoDepth)
  ) uRxFifo (
    .iClock    (iClock),
    .iReset    (iReset),
    .iPush     (rxPush),
    .iPushData (rxShiftR),
    .iPop      (rxPop),
    .oHead     (rxHead),
    .oEmpty    (rxEmpty),
    .oFull     (rxFull)
  );

  sysx_sync_fifo #(
    .pWidth (32),
    .pDepth (pFifoDepth)
  ) uTxFifo (
    .iClock    (iClock),
    .iReset    (iReset),
    .iPush     (txPush),
    .iPushData (iTxData),
    .iPop      (txPop),
    .oHead     (txHead),
    .oEmpty    (txEmpty),
    .oFull     (txFull)
  );

  assign oRxData           = rxHead;
  assign oRxValid          = !rxEmpty;
  assign oTxReady          = !txFull;
  assign oErrors           = errR;
  assign bus.oBusMISO      = misoR;
  assign bus.oBusInterrupt = iIntRequest | !rxEmpty;

endmodule

// File: tb/tb_sysx_slave_endpoint.sv
// -----------------------------------------------------------------------------
// tb_sysx_slave_endpoint
// Drives sysX frames as a bus master and checks the endpoint against a
// queue-based model of the RX/TX FIFOs and the sticky error flags.
// -----------------------------------------------------------------------------
module tb_sysx_slave_endpoint;

  localparam int          cDepth   = 8;
  localparam logic [31:0] cIdle    = 32'h0BADC0DE;
  localparam int          cHalf    = 6;

  logic        iClock;
  logic        iReset;
  logic [31:0] oRxData;
  logic        oRxValid;
  logic        iRxReady;
  logic [31:0] iTxData;
  logic        iTxValid;
  logic        oTxReady;
  logic        iIntRequest;
  logic        iClearErrors;
  logic [2:0]  oErrors;

  sysx_slave_endpoint_if busIf();

  sysx_slave_endpoint #(
    .pDeviceSelect (2'h1),
    .pFifoDepth    (cDepth),
    .pIdleWord     (cIdle)
  ) dut (
    .iClock       (iClock),
    .iReset       (iReset),
    .bus          (busIf),
    .oRxData      (oRxData),
    .oRxValid     (oRxValid),
    .iRxReady     (iRxReady),
    .iTxData      (iTxData),
    .iTxValid     (iTxValid),
    .oTxReady     (oTxReady),
    .iIntRequest  (iIntRequest),
    .iClearErrors (iClearErrors),
    .oErrors      (oErrors)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  // Reference model: plain queues and a flag vector {frame, underflow, overflow}.
  logic [31:0] rxQ[$];
  logic [31:0] txQ[$];
  logic [2:0]  modelErr;

  int errCount   = 0;
  int checkCount = 0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge iClock);
  endtask

  task automatic checkStatus(input string tag);
    checkEq({tag, ".errors"}, {29'd0, oErrors}, {29'd0, modelErr});
    checkEq({tag, ".rxValid"}, {31'd0, oRxValid}, {31'd0, (rxQ.size() != 0)});
    checkEq({tag, ".txReady"}, {31'd0, oTxReady}, {31'd0, (txQ.size() < cDepth)});
    checkEq({tag, ".irq"}, {31'd0, busIf.oBusInterrupt},
            {31'd0, (iIntRequest | (rxQ.size() != 0))});
    if (rxQ.size() != 0) begin
      checkEq({tag, ".rxHead"}, oRxData, rxQ[0]);
    end
  endtask

  task automatic pushTx(input logic [31:0] w);
    if (txQ.size() < cDepth) begin
      iTxValid = 1'b1;
      iTxData  = w;
      tick(1);
      iTxValid = 1'b0;
      txQ.push_back(w);
      tick(1);
    end
  endtask

  task automatic popRx();
    if (rxQ.size() != 0) begin
      checkEq("pop.data", oRxData, rxQ[0]);
      iRxReady = 1'b1;
      tick(1);
      iRxReady = 1'b0;
      void'(rxQ.pop_front());
      tick(1);
    end
  endtask

  task automatic clearErrors();
    iClearErrors = 1'b1;
    tick(1);
    iClearErrors = 1'b0;
    modelErr = 3'b000;
    tick(1);
  endtask

  // Master side of a frame: nFalls bus periods, MISO sampled late in each low half.
  task automatic busFrame(input logic [1:0] sel, input logic [31:0] mosiW,
                          input int nFalls, output logic [31:0] misoW);
    misoW = 32'h0;
    busIf.iBusSelect = sel;
    tick(cHalf);
    for (int k = 0; k < nFalls; k++) begin
      if (k >= 1 && k <= 4) busIf.iBusMOSI = mosiW[8*(k-1) +: 8];
      else                  busIf.iBusMOSI = 8'h00;
      busIf.iBusClock = 1'b0;
      tick(cHalf);
      if (k < 4) misoW[8*k +: 8] = busIf.oBusMISO;
      busIf.iBusClock = 1'b1;
      tick(cHalf);
    end
  endtask

  // Complete selected frame with the model updated from the frame rules.
  task automatic fullFrame(input string tag, input logic [31:0] mosiW);
    logic [31:0] misoW;
    logic [31:0] expTx;
    logic        real_;
    real_ = (txQ.size() != 0);
    expTx = real_ ? txQ[0] : cIdle;
    if (!real_) modelErr[1] = 1'b1;
    busFrame(2'h1, mosiW, 6, misoW);
    if (rxQ.size() == cDepth) modelErr[0] = 1'b1;
    else                      rxQ.push_back(mosiW);
    if (real_) void'(txQ.pop_front());
    checkEq({tag, ".miso"}, misoW, expTx);
    checkStatus(tag);
  endtask

  task automatic deselect();
    busIf.iBusSelect = 2'h0;
    tick(cHalf);
  endtask

  initial begin
    logic [31:0] misoW;
    int          op;

    iReset = 1'b0;
    iRxReady = 1'b0;
    iTxData = 32'h0;
    iTxValid = 1'b0;
    iIntRequest = 1'b0;
    iClearErrors = 1'b0;
    busIf.iBusClock = 1'b1;
    busIf.iBusSelect = 2'h0;
    busIf.iBusMOSI = 8'h00;
    modelErr = 3'b000;

    // Reset values.
    tick(4);
    checkEq("reset.miso", {24'd0, busIf.oBusMISO}, 32'h0);
    checkStatus("reset");
    iReset = 1'b1;
    tick(2);

    // 1: basic frame.
    pushTx(32'h11223344);
    busFrame(2'h1, 32'hDDCCBBAA, 6, misoW);
    txQ.pop_front();
    rxQ.push_back(32'hDDCCBBAA);
    checkEq("t1.miso", misoW, 32'h11223344);
    checkEq("t1.rxData", oRxData, 32'hDDCCBBAA);
    checkStatus("t1");
    deselect();

    // 2: TX empty returns the idle word and flags underflow.
    fullFrame("t2", $urandom);
    checkEq("t2.underflow", {31'd0, oErrors[1]}, 32'd1);
    deselect();
    popRx();
    popRx();
    clearErrors();

    // 3: back-to-back frames overflow RX.
    for (int f = 0; f <= cDepth; f++) begin
      fullFrame("t3", $urandom);
    end
    checkEq("t3.overflow", {31'd0, oErrors[0]}, 32'd1);
    checkEq("t3.rxCount", rxQ.size(), cDepth);
    deselect();
    clearErrors();
    checkEq("t3.cleared", {29'd0, oErrors}, 32'd0);
    while (rxQ.size() != 0) popRx();
    checkStatus("t3.drained");

    // 4: select dropped mid-frame.
    pushTx($urandom);
    busFrame(2'h1, $urandom, 3, misoW);
    deselect();
    modelErr[2] = 1'b1;
    checkEq("t4.frame", {31'd0, oErrors[2]}, 32'd1);
    checkStatus("t4");
    fullFrame("t4.next", $urandom);
    deselect();
    clearErrors();

    // 5: another device's select code.
    pushTx($urandom);
    busFrame(2'h2, $urandom, 6, misoW);
    checkEq("t5.miso", misoW, 32'h0);
    checkStatus("t5");
    fullFrame("t5.next", $urandom);
    deselect();

    // 6: reset in the middle of a frame.
    pushTx($urandom);
    pushTx($urandom);
    busFrame(2'h1, $urandom, 3, misoW);
    iIntRequest = 1'b1;
    iReset = 1'b0;
    tick(3);
    rxQ.delete();
    txQ.delete();
    modelErr = 3'b000;
    checkEq("t6.miso", {24'd0, busIf.oBusMISO}, 32'h0);
    checkStatus("t6.reset");
    busIf.iBusSelect = 2'h0;
    iIntRequest = 1'b0;
    tick(2);
    iReset = 1'b1;
    tick(cHalf);
    checkStatus("t6.release");
    pushTx($urandom);
    fullFrame("t6.next", $urandom);
    deselect();
    popRx();

    // Randomized mix of local pushes/pops, frames and clears.
    for (int i = 0; i < 40; i++) begin
      iIntRequest = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 9);
      if (op < 3)      pushTx($urandom);
      else if (op < 5) popRx();
      else if (op < 9) fullFrame("rnd", $urandom);
      else             clearErrors();
      tick(1);
      checkStatus("rnd.status");
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
